// File: rtl/instr_mem.sv
// Instruction memory loaded one byte at a time (high byte first, then low
// byte) and read combinationally at the current word address.
module instr_mem #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inCmd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_inst,
    output logic [WORD_W-1:0] o_inst
);

    localparam int DEPTH = 1 << ADDR_W;

    // Word storage; each word is assembled from two bytes on consecutive edges.
    logic [WORD_W-1:0] mem [DEPTH];

    // Byte phase: 0 = next loaded byte goes to the high half, 1 = to the low half.
    logic phase;

    // Byte-serial loader. The address is used as presented on each edge, so a
    // word is only complete when both edges target the same address. Any idle
    // cycle re-arms the loader for a high byte. Reset clears all words at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            phase <= 1'b0;
        end else if (inCmd) begin
            if (!phase) begin
                mem[i_addr][WORD_W-1 -: 8] <= i_inst;
            end else begin
                mem[i_addr][7:0] <= i_inst;
            end
            phase <= ~phase;
        end else begin
            phase <= 1'b0;
        end
    end

    // Zero-latency read path, independent of load mode.
    assign o_inst = mem[i_addr];

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed scenarios followed by random
// load/read traffic compared against a simple byte-run reference model.
module tb_instr_mem;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              inCmd;
    logic [ADDR_W-1:0] i_addr;
    logic [7:0]        i_inst;
    logic [WORD_W-1:0] o_inst;

    int tests;
    int failed;

    // Reference model: stored words plus the length of the current run of
    // consecutive load cycles; an even run length means a high byte is next.
    logic [15:0] ref_mem [DEPTH];
    int          load_run;

    instr_mem #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .inCmd (inCmd),
        .i_addr(i_addr),
        .i_inst(i_inst),
        .o_inst(o_inst)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clear the model as reset would.
    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 16'h0000;
        end
        load_run = 0;
    endtask

    // Advance the model by one rising edge with the given inputs.
    task automatic modelEdge(input logic cmd, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        if (cmd) begin
            if (load_run % 2 == 0) begin
                ref_mem[a] = {d, ref_mem[a][7:0]};
            end else begin
                ref_mem[a] = {ref_mem[a][15:8], d};
            end
            load_run = load_run + 1;
        end else begin
            load_run = 0;
        end
    endtask

    // Compare the current read port against an expected word.
    task automatic checkNow(input string tag, input logic [15:0] expected);
        tests++;
        assert (o_inst === expected) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, o_inst, expected);
        end
    endtask

    // Drive one cycle; check old contents before the edge and new contents after.
    task automatic applyStimulus(input logic cmd, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        inCmd  = cmd;
        i_addr = a;
        i_inst = d;
        #1;
        checkNow($sformatf("pre_edge_addr%0d", a), ref_mem[a]);
        @(posedge clk);
        modelEdge(cmd, a, d);
        #1;
        checkNow($sformatf("post_edge_addr%0d", a), ref_mem[a]);
    endtask

    // Read an address in idle mode against a constant and the model, then idle one edge.
    task automatic checkOutput(input string tag, input logic [ADDR_W-1:0] a, input logic [15:0] expected);
        inCmd  = 1'b0;
        i_addr = a;
        #1;
        checkNow(tag, expected);
        checkNow({tag, "_model"}, ref_mem[a]);
        @(posedge clk);
        modelEdge(1'b0, a, 8'h00);
        #1;
    endtask

    // Assert reset mid-cycle, verify immediate clearing and write blocking, then release.
    task automatic doReset();
        rst = 1'b0;
        #1;
        modelReset();
        checkNow("reset_async_clear", 16'h0000);
        inCmd  = 1'b1;
        i_inst = 8'h77;
        @(posedge clk);
        #1;
        checkNow("reset_blocks_write", 16'h0000);
        #2;
        rst = 1'b1;
        #1;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        tests    = 0;
        failed   = 0;
        rst      = 1'b0;
        inCmd    = 1'b0;
        i_addr   = '0;
        i_inst   = 8'h00;
        modelReset();

        #2;
        checkNow("reset_addr0", 16'h0000);
        i_addr = 8'd37;
        #1;
        checkNow("reset_addr37", 16'h0000);
        i_addr = 8'd255;
        #1;
        checkNow("reset_addr255", 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;

        checkOutput("after_reset_addr200", 8'd200, 16'h0000);

        applyStimulus(1'b1, 8'd0, 8'hAB);
        applyStimulus(1'b1, 8'd0, 8'hCD);
        applyStimulus(1'b1, 8'd1, 8'h01);
        applyStimulus(1'b1, 8'd1, 8'h01);
        applyStimulus(1'b1, 8'd2, 8'h24);
        applyStimulus(1'b1, 8'd2, 8'h24);
        applyStimulus(1'b1, 8'd3, 8'h42);
        applyStimulus(1'b1, 8'd3, 8'h42);
        applyStimulus(1'b0, 8'd3, 8'h00);
        checkOutput("load_addr0", 8'd0, 16'hABCD);
        checkOutput("load_addr1", 8'd1, 16'h0101);
        checkOutput("load_addr2", 8'd2, 16'h2424);
        checkOutput("load_addr3", 8'd3, 16'h4242);

        applyStimulus(1'b1, 8'd4, 8'hFF);
        applyStimulus(1'b0, 8'd4, 8'hFF);
        applyStimulus(1'b0, 8'd5, 8'hAA);
        applyStimulus(1'b0, 8'd5, 8'hAA);
        checkOutput("half_word_addr4", 8'd4, 16'hFF00);
        checkOutput("idle_addr5", 8'd5, 16'h0000);

        begin
            logic [15:0] sweep [6];
            sweep = '{16'hABCD, 16'h0101, 16'h2424, 16'h4242, 16'hFF00, 16'h0000};
            for (int a = 0; a < 6; a++) begin
                checkOutput($sformatf("sweep_addr%0d", a), a[ADDR_W-1:0], sweep[a]);
            end
        end

        applyStimulus(1'b1, 8'd7, 8'h12);
        doReset();
        checkOutput("reset_cleared_addr0", 8'd0, 16'h0000);
        applyStimulus(1'b1, 8'd7, 8'h34);
        applyStimulus(1'b1, 8'd7, 8'h56);
        checkOutput("reload_addr7", 8'd7, 16'h3456);

        applyStimulus(1'b1, 8'd9, 8'h5A);
        applyStimulus(1'b0, 8'd9, 8'h00);
        applyStimulus(1'b1, 8'd9, 8'h11);
        applyStimulus(1'b1, 8'd9, 8'h22);
        checkOutput("restart_addr9", 8'd9, 16'h1122);

        applyStimulus(1'b1, 8'd20, 8'hC3);
        applyStimulus(1'b1, 8'd21, 8'h3C);
        checkOutput("split_addr20", 8'd20, 16'hC300);
        checkOutput("split_addr21", 8'd21, 16'h003C);

        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] ra;
            logic              rc;
            ra = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                             : ADDR_W'($urandom_range(0, 15));
            rc = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                applyStimulus(rc, ra, 8'($urandom_range(0, 255)));
            end
        end

        for (int a = 0; a < 16; a++) begin
            inCmd  = 1'b0;
            i_addr = a[ADDR_W-1:0];
            #1;
            checkNow($sformatf("final_addr%0d", a), ref_mem[a]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter ADDR_W, default 8, address width; memory depth SHALL be 2**ADDR_W words.
REQ-002 Parameter WORD_W, default 16, instruction word width; SHALL equal 2 x byte width (8).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 inCmd  input  1  load-mode enable; 1 = byte-serial instruction loading, 0 = read-only.
REQ-006 i_addr  input  ADDR_W  word address for both load and read.
REQ-007 i_inst  input  8  load data byte; high byte first, then low byte.
REQ-008 o_inst  output  WORD_W  instruction word at i_addr.

Function
REQ-009 Storage SHALL be a 2**ADDR_W x WORD_W array plus a 1-bit byte-phase register (0 = expect high byte, 1 = expect low byte).
REQ-010 Rising edge with inCmd=1 and phase=0: mem[i_addr][15:8] <= i_inst, mem[i_addr][7:0] unchanged, phase <= 1.
REQ-011 Rising edge with inCmd=1 and phase=1: mem[i_addr][7:0] <= i_inst, mem[i_addr][15:8] unchanged, phase <= 0.
REQ-012 Rising edge with inCmd=0: no memory write; phase <= 0.
REQ-013 A full word load SHALL take exactly 2 consecutive cycles with inCmd=1; i_addr SHALL be sampled independently on each of the 2 edges (no internal address latch).
REQ-014 o_inst SHALL be a combinational read, o_inst = mem[i_addr], valid in the same cycle i_addr changes, 0 latency, regardless of inCmd.
REQ-015 Simultaneous read and write of the same address: o_inst SHALL show the old contents until the edge, then the new contents.
REQ-016 Write with inCmd=1 dropping to 0 between high and low byte: high byte SHALL remain written, low byte SHALL remain as before, phase SHALL return to 0.
REQ-017 Address wrap: none needed; i_addr covers the full depth exactly.
REQ-018 No byte value is special inside the block; end-of-program detection (e.g. 0xFF 0xFF) is the controller's job, which deasserts inCmd.

Reset
REQ-019 rst=0 SHALL immediately, without waiting for a clock edge, clear every memory word to 16'h0000 and set phase to 0.
REQ-020 While rst=0, no writes SHALL occur, and o_inst SHALL read 16'h0000 for any i_addr.
REQ-021 Release of rst SHALL be synchronized by the user; the first write SHALL be on the first rising edge after rst=1 with inCmd=1.
REQ-022 Reset asserted mid-word (phase=1) SHALL abort the word; the next load SHALL start with a high byte.

Verification
REQ-023 Reset, then any i_addr -> o_inst = 16'h0000.
REQ-024 Load addr0=ABCD, addr1=0101, addr2=2424, addr3=4242 (2 cycles each, inCmd=1), then inCmd=0 -> reads 0:ABCD, 1:0101, 2:2424, 3:4242.
REQ-025 Addr4: high byte FF with inCmd=1, low byte FF with inCmd=0; then addr5 bytes AA,AA with inCmd=0 -> reads 4:FF00, 5:0000.
REQ-026 Change i_addr each cycle 0..5 with inCmd=0 -> o_inst updates combinationally in the same cycle; no writes.
REQ-027 Load addr7 high byte 12, assert rst (low) before the low byte, release, then load addr7=3456 -> read 7:3456; phase was restarted after reset.
REQ-028 inCmd=1 for high byte 5A at addr9, inCmd=0 one cycle, then inCmd=1 with bytes 11,22 at addr9 -> read 9:1122.
